autoshutdown_timer_mc: RTL and testbench

Multi-channel auto-shutdown timer for the controller: each channel counts idle cycles (no infrared presence while enabled) and signals shutdown when a programmable timeout expires. It is the parametrised successor of the single-channel shutdown timer. It adds channel count, counter width, a pre-shutdown warning, immediate abort on activity, and selectable pulse/level output modes. It sits between the sensor/enable logic and the actuator control stage, one channel per controlled outlet.

---
 rtl/autoshutdown_pkg.sv | 17 +
 rtl/autoshutdown_channel.sv | 75 +++++++
 rtl/autoshutdown_timer_mc.sv | 42 ++++
 tb/tb_autoshutdown_timer_mc.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/autoshutdown_pkg.sv
// Shared types for the multi-channel auto-shutdown timer.
package autoshutdown_pkg;

  typedef enum logic [1:0] {
    ASD_PULSE_REPEAT = 2'd0,
    ASD_PULSE_ONCE   = 2'd1,
    ASD_LEVEL        = 2'd2
  } asd_mode_e;

  typedef enum logic [1:0] {
    ASD_IDLE     = 2'd0,
    ASD_COUNTING = 2'd1,
    ASD_FIRE     = 2'd2,
    ASD_HOLD     = 2'd3
  } asd_state_e;

endpackage

// File: rtl/autoshutdown_channel.sv
// One shutdown channel: idle-cycle counter, FSM and Moore-decoded warn/C.
module autoshutdown_channel
  import autoshutdown_pkg::*;
#(
  parameter int        CNT_W   = 16,
  parameter int        TIMEOUT = 30000,
  parameter int        WARN_T  = 25000,
  parameter asd_mode_e MODE    = ASD_PULSE_REPEAT
) (
  input  logic clk,
  input  logic rst,
  input  logic infra,
  input  logic enable,
  output logic warn,
  output logic C
);

  if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
    $fatal(1, "autoshutdown_channel: TIMEOUT out of range for CNT_W");
  end
  if (WARN_T < 1 || WARN_T >= TIMEOUT) begin : g_bad_warn
    $fatal(1, "autoshutdown_channel: WARN_T must be in [1, TIMEOUT)");
  end

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_T);

  asd_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             idle;

  assign idle = !infra && enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ASD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ASD_IDLE: begin
          cnt <= '0;
          if (idle) state <= ASD_COUNTING;
        end
        ASD_COUNTING: begin
          // Activity wins over expiry when both land on the same edge.
          if (!idle) begin
            state <= ASD_IDLE;
            cnt   <= '0;
          end else if (cnt < LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state <= ASD_FIRE;
            cnt   <= '0;
          end
        end
        ASD_FIRE: begin
          cnt   <= '0;
          state <= (MODE == ASD_PULSE_REPEAT) ? ASD_IDLE : ASD_HOLD;
        end
        ASD_HOLD: begin
          cnt <= '0;
          if (!idle) state <= ASD_IDLE;
        end
        default: begin
          state <= ASD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign warn = (state == ASD_COUNTING) && (cnt >= WARN_C);
  assign C    = (state == ASD_FIRE) || ((state == ASD_HOLD) && (MODE == ASD_LEVEL));

endmodule

// File: rtl/autoshutdown_timer_mc.sv
// N_CH independent auto-shutdown channels with a combined shutdown flag.
module autoshutdown_timer_mc
  import autoshutdown_pkg::*;
#(
  parameter int        N_CH    = 4,
  parameter int        CNT_W   = 16,
  parameter int        TIMEOUT = 30000,
  parameter int        WARN_T  = 25000,
  parameter asd_mode_e MODE    = ASD_PULSE_REPEAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] infra,
  input  logic [N_CH-1:0] enable,
  output logic [N_CH-1:0] warn,
  output logic [N_CH-1:0] C,
  output logic            any_C
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $fatal(1, "autoshutdown_timer_mc: N_CH must be in [1, 16]");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    autoshutdown_channel #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT),
      .WARN_T (WARN_T),
      .MODE   (MODE)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .infra (infra[i]),
      .enable(enable[i]),
      .warn  (warn[i]),
      .C     (C[i])
    );
  end

  assign any_C = |C;

endmodule

// File: tb/tb_autoshutdown_timer_mc.sv
// Directed bench: one DUT per output mode, all driven by the same channel inputs.
module tb_autoshutdown_timer_mc;
  import autoshutdown_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] infra, enable;
  logic [1:0] warn_r, c_r, warn_l, c_l, warn_o, c_o;
  logic       any_r, any_l, any_o;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  autoshutdown_timer_mc #(.N_CH(2), .CNT_W(8), .TIMEOUT(10), .WARN_T(7), .MODE(ASD_PULSE_REPEAT)) u_rep (
    .clk(clk), .rst(rst), .infra(infra), .enable(enable), .warn(warn_r), .C(c_r), .any_C(any_r));
  autoshutdown_timer_mc #(.N_CH(2), .CNT_W(8), .TIMEOUT(10), .WARN_T(7), .MODE(ASD_LEVEL)) u_lvl (
    .clk(clk), .rst(rst), .infra(infra), .enable(enable), .warn(warn_l), .C(c_l), .any_C(any_l));
  autoshutdown_timer_mc #(.N_CH(2), .CNT_W(8), .TIMEOUT(10), .WARN_T(7), .MODE(ASD_PULSE_ONCE)) u_once (
    .clk(clk), .rst(rst), .infra(infra), .enable(enable), .warn(warn_o), .C(c_o), .any_C(any_o));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    infra  = 2'b00;
    enable = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    infra  = 2'b00;
    enable = 2'b00;
    #2;
    chk("rst_warn_r", int'(warn_r), 0);
    chk("rst_c_r",    int'(c_r),    0);
    chk("rst_c_l",    int'(c_l),    0);
    chk("rst_any_o",  int'(any_o),  0);
    tick();
    rst = 1'b0;
    tick();

    // Repeat mode: ch0 idle, ch1 disabled
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk("rep_warn0", int'(warn_r[0]), int'((e >= 7 && e <= 9) || (e >= 19 && e <= 21)));
      chk("rep_c0",    int'(c_r[0]),    int'(e == 10 || e == 22));
      chk("rep_any",   int'(any_r),     int'(e == 10 || e == 22));
      chk("rep_ch1",   int'({warn_r[1], c_r[1]}), 0);
    end
    park();

    // One-cycle presence at counter 5 restarts the count
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 18; e++) begin
      infra[0] = (e == 6);
      tick();
      chk("abort5_c0",    int'(c_r[0]),    int'(e == 17));
      chk("abort5_warn0", int'(warn_r[0]), int'(e >= 14 && e <= 16));
    end
    park();

    // Presence exactly at counter 9 suppresses the expiry
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 14; e++) begin
      infra[0] = (e >= 10);
      tick();
      chk("abort9_c0",    int'(c_r[0]),    0);
      chk("abort9_warn0", int'(warn_r[0]), int'(e >= 7 && e <= 9));
    end
    park();

    // Level and pulse-once modes with idle held
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("lvl_c0",   int'(c_l[0]), int'(e >= 10));
      chk("once_c0",  int'(c_o[0]), int'(e == 10));
      chk("lvl_any",  int'(any_l),  int'(e >= 10));
      chk("lvl_warn", int'(warn_l[0]), int'(e >= 7 && e <= 9));
    end
    enable = 2'b00;
    #1;
    chk("lvl_hold_before_edge", int'(c_l[0]), 1);
    tick();
    chk("lvl_fall", int'(c_l[0]), 0);
    chk("once_quiet", int'(c_o[0]), 0);
    tick();

    // Async reset while level output is high
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 10; e++) tick();
    chk("lvl_pre_rst", int'(c_l[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_c_l",  int'(c_l),   0);
    chk("rst_mid_any",  int'(any_l), 0);
    chk("rst_mid_warn", int'(warn_l | warn_r | warn_o), 0);
    rst = 1'b0;
    tick();
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("post_rst_lvl_c0", int'(c_l[0]), int'(e == 10));
    end
    park();

    // Async reset at counter 4: warn must take 7 full edges after restart
    enable = 2'b01;
    tick();
    for (int e = 1; e <= 4; e++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst4_warn_r", int'(warn_r), 0);
    chk("rst4_c_r",    int'(c_r),    0);
    rst = 1'b0;
    tick();
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("rst4_restart_warn", int'(warn_r[0]), int'(e == 7));
    end
    park();

    // Two channels start together; ch1 sees presence at counter 3
    enable = 2'b11;
    tick();
    for (int e = 1; e <= 16; e++) begin
      infra[1] = (e == 4);
      tick();
      chk("ind_c0",  int'(c_r[0]), int'(e == 10));
      chk("ind_c1",  int'(c_r[1]), int'(e == 15));
      chk("ind_any", int'(any_r),  int'(e == 10 || e == 15));
    end
    park();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
